// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file for the RV32I pipeline.
// Selects the WB result, commits it to x1..x31 and serves two bypassed read ports.
module writeback_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteW,
    input  logic [1:0]            ResultSrcW,
    input  logic [DATA_WIDTH-1:0] ALUResultW,
    input  logic [DATA_WIDTH-1:0] ReadDataW,
    input  logic [DATA_WIDTH-1:0] PC_PlusW,
    input  logic [4:0]            RdW,
    input  logic [4:0]            A1,
    input  logic [4:0]            A2,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic [DATA_WIDTH-1:0] a0
);

    // x0 has no storage; only x1..x31 are real registers
    logic [DATA_WIDTH-1:0] regs [1:REG_COUNT-1];
    logic                  commitEn;

    always_comb begin
        ResultW = ALUResultW;
        case (ResultSrcW)
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PC_PlusW;
            default: ResultW = ALUResultW;
        endcase
    end

    assign commitEn = RegWriteW && (RdW != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (commitEn) begin
            regs[RdW] <= ResultW;
        end
    end

    // Write-through bypass lets decode see the WB result in the same cycle
    always_comb begin
        RD1 = '0;
        if (rst_n && (A1 != 5'd0)) begin
            if (commitEn && (A1 == RdW)) begin
                RD1 = ResultW;
            end else begin
                RD1 = regs[A1];
            end
        end
    end

    always_comb begin
        RD2 = '0;
        if (rst_n && (A2 != 5'd0)) begin
            if (commitEn && (A2 == RdW)) begin
                RD2 = ResultW;
            end else begin
                RD2 = regs[A2];
            end
        end
    end

    assign a0 = regs[10];

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed vector table, a mid-cycle reset sequence,
// and randomized traffic checked against an array-based reference model.
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PC_PlusW;
    logic [4:0]  RdW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] a0;

    int vectorsApplied = 0;
    int miscompares    = 0;

    writeback_regfile #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PC_PlusW   (PC_PlusW),
        .RdW        (RdW),
        .A1         (A1),
        .A2         (A2),
        .RD1        (RD1),
        .RD2        (RD2),
        .ResultW    (ResultW),
        .a0         (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        rw;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] expRd1;
        logic [31:0] expRd2;
        logic [31:0] expRes;
        logic [31:0] expA0;
    } vec_t;

    vec_t vecs [0:17];

    // Drive one set of inputs at the falling edge; outputs settle 1 time unit later
    task automatic applyStimulus(input logic rstn, input logic rw, input logic [1:0] src,
                                 input logic [31:0] alu, input logic [31:0] rdata,
                                 input logic [31:0] pc, input logic [4:0] rd,
                                 input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        rst_n      = rstn;
        RegWriteW  = rw;
        ResultSrcW = src;
        ALUResultW = alu;
        ReadDataW  = rdata;
        PC_PlusW   = pc;
        RdW        = rd;
        A1         = a1;
        A2         = a2;
        vectorsApplied++;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    logic [31:0] model [0:31];

    initial begin
        rst_n = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00;
        ALUResultW = '0; ReadDataW = '0; PC_PlusW = '0;
        RdW = '0; A1 = '0; A2 = '0;

        //            rstn rw  src    alu           rdata  pc     rd     a1     a2     RD1           RD2           Res           a0
        vecs[0]  = '{1'b0,1'b0,2'b00,32'h0,        32'h0, 32'h0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b1,1'b1,2'b00,32'hA,        32'hB, 32'hC, 5'd3,  5'd3,  5'd0,  32'hA,        32'h0,        32'hA,        32'h0};
        vecs[2]  = '{1'b1,1'b1,2'b01,32'hA,        32'hB, 32'hC, 5'd3,  5'd3,  5'd0,  32'hB,        32'h0,        32'hB,        32'h0};
        vecs[3]  = '{1'b1,1'b1,2'b10,32'hA,        32'hB, 32'hC, 5'd3,  5'd3,  5'd0,  32'hC,        32'h0,        32'hC,        32'h0};
        vecs[4]  = '{1'b1,1'b1,2'b11,32'hA,        32'hB, 32'hC, 5'd3,  5'd3,  5'd0,  32'hA,        32'h0,        32'hA,        32'h0};
        vecs[5]  = '{1'b1,1'b0,2'b00,32'h0,        32'h0, 32'h0, 5'd3,  5'd3,  5'd3,  32'hA,        32'hA,        32'h0,        32'h0};
        vecs[6]  = '{1'b1,1'b1,2'b00,32'hFFFFFFFF, 32'h0, 32'h0, 5'd0,  5'd0,  5'd3,  32'h0,        32'hA,        32'hFFFFFFFF, 32'h0};
        vecs[7]  = '{1'b1,1'b0,2'b00,32'h0,        32'h0, 32'h0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[8]  = '{1'b1,1'b1,2'b00,32'h11,       32'h0, 32'h0, 5'd7,  5'd0,  5'd0,  32'h0,        32'h0,        32'h11,       32'h0};
        vecs[9]  = '{1'b1,1'b1,2'b00,32'h22,       32'h0, 32'h0, 5'd7,  5'd7,  5'd7,  32'h22,       32'h22,       32'h22,       32'h0};
        vecs[10] = '{1'b1,1'b0,2'b00,32'h0,        32'h0, 32'h0, 5'd7,  5'd7,  5'd7,  32'h22,       32'h22,       32'h0,        32'h0};
        vecs[11] = '{1'b1,1'b1,2'b00,32'h11,       32'h0, 32'h0, 5'd7,  5'd7,  5'd0,  32'h11,       32'h0,        32'h11,       32'h0};
        vecs[12] = '{1'b1,1'b0,2'b00,32'h33,       32'h0, 32'h0, 5'd7,  5'd7,  5'd7,  32'h11,       32'h11,       32'h33,       32'h0};
        vecs[13] = '{1'b1,1'b1,2'b00,32'h99,       32'h0, 32'h0, 5'd10, 5'd10, 5'd0,  32'h99,       32'h0,        32'h99,       32'h0};
        vecs[14] = '{1'b1,1'b0,2'b00,32'h0,        32'h0, 32'h0, 5'd10, 5'd10, 5'd0,  32'h99,       32'h0,        32'h0,        32'h99};
        vecs[15] = '{1'b1,1'b1,2'b00,32'h1234,     32'h0, 32'h0, 5'd5,  5'd5,  5'd10, 32'h1234,     32'h99,       32'h1234,     32'h99};
        vecs[16] = '{1'b0,1'b1,2'b00,32'h77,       32'h0, 32'h0, 5'd4,  5'd4,  5'd10, 32'h0,        32'h0,        32'h77,       32'h0};
        vecs[17] = '{1'b1,1'b0,2'b00,32'h0,        32'h0, 32'h0, 5'd4,  5'd4,  5'd5,  32'h0,        32'h0,        32'h0,        32'h0};

        $display("[TB] directed vector table");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].rw, vecs[i].src, vecs[i].alu, vecs[i].rdata,
                          vecs[i].pc, vecs[i].rd, vecs[i].a1, vecs[i].a2);
            checkOutput($sformatf("vec%0d RD1", i),     RD1,     vecs[i].expRd1);
            checkOutput($sformatf("vec%0d RD2", i),     RD2,     vecs[i].expRd2);
            checkOutput($sformatf("vec%0d ResultW", i), ResultW, vecs[i].expRes);
            checkOutput($sformatf("vec%0d a0", i),      a0,      vecs[i].expA0);
        end

        // Asynchronous reset pulled between edges after preloading x5 and x10
        $display("[TB] mid-cycle reset sequence");
        applyStimulus(1'b1, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b1, 2'b00, 32'h55,   32'h0, 32'h0, 5'd10, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 2'b00, 32'hAB,   32'h0, 32'h0, 5'd0, 5'd5, 5'd10);
        checkOutput("preload x5",  RD1, 32'h1234);
        checkOutput("preload x10", RD2, 32'h55);
        checkOutput("preload a0",  a0,  32'h55);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async rst RD1", RD1, 32'h0);
        checkOutput("async rst RD2", RD2, 32'h0);
        checkOutput("async rst a0",  a0,  32'h0);
        checkOutput("rst ResultW live", ResultW, 32'hAB);
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd10);
        checkOutput("post-rst x5",  RD1, 32'h0);
        checkOutput("post-rst x10", RD2, 32'h0);

        // Randomized traffic against the reference model (array is all-zero after reset)
        $display("[TB] randomized traffic");
        for (int r = 0; r < 32; r++) model[r] = '0;
        for (int n = 0; n < 400; n++) begin
            logic        rstn, rw, doWrite;
            logic [1:0]  src;
            logic [31:0] alu, rdata, pc, res, e1, e2, eA0;
            logic [4:0]  rd, a1, a2;
            rstn  = ($urandom_range(0, 24) != 0);
            rw    = ($urandom_range(0, 3) != 0);
            src   = 2'($urandom_range(0, 3));
            alu   = $urandom;
            rdata = $urandom;
            pc    = $urandom;
            rd    = 5'($urandom_range(0, 11));
            a1    = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2    = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 11));

            if (!rstn) for (int r = 0; r < 32; r++) model[r] = '0;
            res     = (src == 2'd1) ? rdata : (src == 2'd2) ? pc : alu;
            doWrite = rstn && rw && (rd != 0);
            e1  = (!rstn || a1 == 0) ? 32'h0 : (doWrite && a1 == rd) ? res : model[a1];
            e2  = (!rstn || a2 == 0) ? 32'h0 : (doWrite && a2 == rd) ? res : model[a2];
            eA0 = model[10];

            applyStimulus(rstn, rw, src, alu, rdata, pc, rd, a1, a2);
            checkOutput($sformatf("rnd%0d RD1", n),     RD1,     e1);
            checkOutput($sformatf("rnd%0d RD2", n),     RD2,     e2);
            checkOutput($sformatf("rnd%0d ResultW", n), ResultW, res);
            checkOutput($sformatf("rnd%0d a0", n),      a0,      eA0);
            if (doWrite) model[rd] = res;
        end

        // Final sweep: read every register back through both ports
        for (int r = 0; r < 32; r += 2) begin
            applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'(r), 5'(r + 1));
            checkOutput($sformatf("sweep x%0d", r),     RD1, (r == 0) ? 32'h0 : model[r]);
            checkOutput($sformatf("sweep x%0d", r + 1), RD2, model[r + 1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
